addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit; next-generation replacement for the fixed 16-bit registered subtractor in the ALU.
- Adds: configurable width, add/sub/add-with-carry/sub-with-borrow ops, signed/unsigned saturation, status flags and valid/ready handshakes on both sides.
- Sits between the ALU operand mux and the result writeback; the carry register enables multi-word arithmetic.

Parameters:
- WIDTH, 16, operand and result width in bits (minimum 2).

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  2  00 ADD, 01 SUB, 10 ADDC, 11 SUBB
- sat_en  in  1  saturate on overflow for this beat
- signed_mode  in  1  1 = two's-complement interpretation for saturation
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  final (possibly saturated) result
- carry  out  1  carry-out (ADD/ADDC) or borrow (SUB/SUBB) of the raw operation
- overflow  out  1  signed overflow of the raw operation
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- Reset (async, immediate):
  - S1 valid, out_valid, result, carry, overflow, zero and negative all cleared to 0.
  - Internal carry register cleared to 0.
  - In-flight beats are discarded.
  - in_ready = 1 once rst deasserts.
- Pipeline, two register stages:
  - S1 captures a, b, op, sat_en and signed_mode on in_valid && in_ready.
  - S2 is the output register. It computes from the S1 contents and loads when S1 is valid and (!out_valid || out_ready).
- Latency: a beat accepted at edge N presents out_valid=1 after edge N+1 when there is no backpressure. Full throughput is one beat per cycle.
- Handshake:
  - in_ready = !s1_valid || !out_valid || out_ready.
  - out_valid is cleared on out_valid && out_ready unless a new beat loads the same cycle.
  - Outputs are held stable while out_valid && !out_ready.
  - Order is preserved; no loss or duplication.
- Carry register C:
  - Updated with the carry output each time S2 loads.
  - Read by ADDC/SUBB in S2, so back-to-back multi-word ops chain correctly.
  - Not changed while stalled.
- Arithmetic, computed at WIDTH+1 bits unsigned:
  - ADD: a+b. SUB: a-b. ADDC: a+b+C. SUBB: a-b-C.
  - carry = bit WIDTH of the add sum, or the borrow (1 if unsigned a < b+Cin) for subtract.
  - overflow = standard signed overflow of the raw WIDTH-bit result, independent of signed_mode.
- Saturation, only when sat_en=1:
  - signed_mode=1 and overflow=1: clamp to 0111..1 if the true result is positive, otherwise 1000..0.
  - signed_mode=0 and an add op with carry=1: clamp to all-ones.
  - signed_mode=0 and a subtract op with borrow=1: clamp to 0.
  - Otherwise the raw result passes through.
- Flags:
  - carry and overflow always reflect the raw operation.
  - zero and negative reflect the final result.
  - All flags are registered with result and share out_valid.
- Simultaneous events: in-accept, S1→S2 transfer and out-handshake may all happen in one cycle.
- Reset mid-operation: everything is flushed; the first beat after reset sees C=0.
- Invalid-cycle contents of result and flags: hold last value, never X after reset.

Test Plan:
- SUB 0005-0003, unsigned, no sat, out_ready=1 → result 0002, carry 0, overflow 0, zero 0, negative 0; out_valid asserted after the second edge following accept.
- SUB 0003-0005 → FFFE, carry 1, negative 1. Same with sat_en=1, signed_mode=0 → 0000, carry 1, zero 1.
- ADD FFFF+0001 then back-to-back ADDC 0000+0000 → 0000 (carry 1, zero 1), then 0001 (carry 0). SUBB 0000-0000 after a borrow → FFFF, carry 1.
- Signed saturation:
  - ADD 7FFF+0001, sat_en=1, signed_mode=1 → 7FFF, overflow 1.
  - Same without saturation → 8000, overflow 1, negative 1.
  - SUB 8000-0001, sat → 8000.
- Backpressure: hold out_ready=0 while driving 4 consecutive beats → in_ready drops after 2 beats are accepted. Release → results emerge in order, one per cycle, none lost or duplicated. Flags stay stable while stalled.
- Assert rst with both stages full and C=1 → out_valid, result, flags and C are 0 immediately without a clock edge. After release, ADDC 0001+0001 → 0002, carry 0.

Source files
------------

// File: rtl/addsub_pipe.sv
// Two-stage pipelined add/subtract unit with carry chaining, optional signed or
// unsigned saturation, status flags and valid/ready handshakes on both sides.
module addsub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             sat_en,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] saturate(
    input logic [WIDTH-1:0] raw,
    input logic             a_msb,
    input logic             is_sub,
    input logic             carry_bit,
    input logic             ovf,
    input logic             sat,
    input logic             sgn
  );
    logic [WIDTH-1:0] res;
    res = raw;
    if (sat) begin
      if (sgn) begin
        // on signed overflow the true result has the sign of operand a
        if (ovf) res = a_msb ? SMIN : SMAX;
      end else if (carry_bit) begin
        res = is_sub ? '0 : '1;
      end
    end
    return res;
  endfunction

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [1:0]       op_p1;
  logic             sat_p1;
  logic             sgn_p1;
  logic             c_reg;
  logic             accept;
  logic             load_p2;

  assign in_ready = !vld_p1 || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign load_p2  = vld_p1 && (!out_valid || out_ready);

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (load_p2) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1   <= a;
      b_p1   <= b;
      op_p1  <= op;
      sat_p1 <= sat_en;
      sgn_p1 <= signed_mode;
    end
  end

  logic             is_sub_p1;
  logic             cin_p1;
  logic [WIDTH:0]   wide_p1;
  logic [WIDTH-1:0] raw_p1;
  logic [WIDTH-1:0] fin_p1;
  logic             carry_p1;
  logic             ovf_p1;

  always_comb begin
    is_sub_p1 = op_p1[0];
    cin_p1    = op_p1[1] & c_reg;
    if (is_sub_p1) begin
      wide_p1 = {1'b0, a_p1} - {1'b0, b_p1} - {{WIDTH{1'b0}}, cin_p1};
    end else begin
      wide_p1 = {1'b0, a_p1} + {1'b0, b_p1} + {{WIDTH{1'b0}}, cin_p1};
    end
    raw_p1   = wide_p1[WIDTH-1:0];
    carry_p1 = wide_p1[WIDTH];
    if (is_sub_p1) begin
      ovf_p1 = (a_p1[WIDTH-1] != b_p1[WIDTH-1]) && (raw_p1[WIDTH-1] != a_p1[WIDTH-1]);
    end else begin
      ovf_p1 = (a_p1[WIDTH-1] == b_p1[WIDTH-1]) && (raw_p1[WIDTH-1] != a_p1[WIDTH-1]);
    end
    fin_p1 = saturate(raw_p1, a_p1[WIDTH-1], is_sub_p1, carry_p1, ovf_p1, sat_p1, sgn_p1);
  end

  // ---- stage 2: result, flags and chaining carry ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      c_reg     <= 1'b0;
    end else if (load_p2) begin
      out_valid <= 1'b1;
      result    <= fin_p1;
      carry     <= carry_p1;
      overflow  <= ovf_p1;
      zero      <= (fin_p1 == '0);
      negative  <= fin_p1[WIDTH-1];
      c_reg     <= carry_p1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed scenarios with literal expectations plus a
// randomized run scored against an arithmetic model of the unit.
module tb_addsub_pipe;
  localparam int W = 16;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ADDC = 2'b10, SUBB = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = ADD;
  logic         sat_en = 1'b0;
  logic         signed_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry, overflow, zero, negative;

  addsub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .sat_en(sat_en), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic c, o, z, n;
  } exp_t;

  exp_t q[$];
  logic mc = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   pops = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Carry-chain model: the true sum/difference in wide integers, then the flags
  // and clamping follow from range tests on that true value.
  function automatic exp_t model(input logic [W-1:0] ma, mb, input logic [1:0] mop,
                                 input logic msat, msgn);
    exp_t e;
    longint ua, ub, sa, sb, cin, u, s, smax, smin;
    logic [W-1:0] fin;
    smax = (longint'(1) << (W-1)) - 1;
    smin = -(longint'(1) << (W-1));
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    cin = mop[1] ? longint'(mc) : 0;
    if (mop[0]) begin
      u = ua - ub - cin;
      s = sa - sb - cin;
      e.c = (u < 0);
    end else begin
      u = ua + ub + cin;
      s = sa + sb + cin;
      e.c = (u >= (longint'(1) << W));
    end
    fin = u[W-1:0];
    e.o = (s > smax) || (s < smin);
    if (msat && msgn && e.o) fin = (s > 0) ? smax[W-1:0] : smin[W-1:0];
    else if (msat && !msgn && e.c) fin = mop[0] ? '0 : '1;
    mc  = e.c;
    e.r = fin;
    e.z = (fin == '0);
    e.n = fin[W-1];
    return e;
  endfunction

  // One cycle: drive at negedge, settle, score the output side, record an accept.
  task automatic step(input logic iv, input logic [W-1:0] ia, ib, input logic [1:0] iop,
                      input logic isat, isgn, input logic ordy, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; op = iop;
    sat_en = isat; signed_mode = isgn; out_ready = ordy;
    #1;
    if (out_valid) begin
      chk("sb_pending", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q[0];
        chk("sb_out", 32'({result, carry, overflow, zero, negative}),
            32'({e.r, e.c, e.o, e.z, e.n}));
        if (out_ready) begin
          void'(q.pop_front());
          pops++;
        end
      end
    end
    acc = in_valid && in_ready;
    if (acc) q.push_back(model(ia, ib, iop, isat, isgn));
  endtask

  task automatic beat(input logic [W-1:0] ia, ib, input logic [1:0] iop, input logic isat, isgn);
    logic acc;
    step(1'b1, ia, ib, iop, isat, isgn, 1'b1, acc);
    chk("beat_accepted", 32'(acc), 32'd1);
  endtask

  task automatic idle();
    logic acc;
    step(1'b0, '0, '0, ADD, 1'b0, 1'b0, 1'b1, acc);
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] r, input logic c, o, z, n);
    chk(tag, 32'({out_valid, result, carry, overflow, zero, negative}), 32'({1'b1, r, c, o, z, n}));
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = 16'h0001;
      2: v = 16'h7FFF;
      3: v = 16'h8000;
      4: v = 16'hFFFF;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    logic acc;
    int   idx;
    int   pops0;
    logic [W-1:0] ta;

    // reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_out", 32'({out_valid, result, carry, overflow, zero, negative}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    // latency and basic subtract
    beat(16'h0005, 16'h0003, SUB, 1'b0, 1'b0);
    idle();
    chk("latency_n1", 32'(out_valid), 32'd0);
    idle();
    expect_out("sub_5_3", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    // borrow, unsigned clamp to zero
    beat(16'h0003, 16'h0005, SUB, 1'b0, 1'b0);
    beat(16'h0003, 16'h0005, SUB, 1'b1, 1'b0);
    idle();
    expect_out("sub_3_5", 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
    idle();
    expect_out("sub_3_5_sat", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // multi-word chaining, back to back
    beat(16'hFFFF, 16'h0001, ADD, 1'b0, 1'b0);
    beat(16'h0000, 16'h0000, ADDC, 1'b0, 1'b0);
    beat(16'h0000, 16'h0001, SUB, 1'b0, 1'b0);
    expect_out("add_ffff_1", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    beat(16'h0000, 16'h0000, SUBB, 1'b0, 1'b0);
    expect_out("addc_chain", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    expect_out("sub_0_1", 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    idle();
    expect_out("subb_chain", 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);

    // signed overflow with and without clamping
    beat(16'h7FFF, 16'h0001, ADD, 1'b1, 1'b1);
    beat(16'h7FFF, 16'h0001, ADD, 1'b0, 1'b1);
    beat(16'h8000, 16'h0001, SUB, 1'b1, 1'b1);
    expect_out("sadd_sat", 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    expect_out("sadd_nosat", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    expect_out("ssub_sat", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    idle();

    // backpressure: four beats offered while the sink is stalled
    idx = 0;
    pops0 = pops;
    for (int cyc = 0; cyc < 12; cyc++) begin
      ta = W'(16'h0100 + idx);
      step(idx < 4, ta, W'(idx), ADD, 1'b0, 1'b0, cyc >= 4, acc);
      if (cyc == 2 || cyc == 3) chk("bp_in_ready", 32'(in_ready), 32'd0);
      if (cyc == 3) expect_out("bp_hold", 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd4);
    chk("bp_delivered", 32'(pops - pops0), 32'd4);

    // reset with both stages full and the chain carry set
    step(1'b1, 16'hFFFF, 16'h0001, ADD, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 16'h0001, 16'h0001, ADD, 1'b0, 1'b0, 1'b0, acc);
    step(1'b0, '0, '0, ADD, 1'b0, 1'b0, 1'b0, acc);
    chk("full_pre_rst", 32'({out_valid, in_ready, carry}), 32'b101);
    #1 rst = 1'b1;
    #1 chk("async_rst", 32'({out_valid, result, carry, overflow, zero, negative}), 32'd0);
    q.delete();
    mc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    beat(16'h0001, 16'h0001, ADDC, 1'b0, 1'b0);
    idle();
    idle();
    expect_out("addc_after_rst", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, pick(), pick(), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 7, acc);
    end
    for (int i = 0; i < 5; i++) idle();
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
